// File: rtl/rp_dv_decim.sv
// Multi-channel programmable data-valid decimator: passes 1 of every ratio valids per channel, realigned by sync_i.
// Optional per-channel drop statistics are built when RP_DV_DECIM_STAT_EN is defined.
module rp_dv_decim #(
    parameter int CH = 2,
    parameter int DW = 14,
    parameter int CW = 8
) (
    input  logic             adc_clk_i,
    input  logic             adc_rst_i,
    input  logic [CH-1:0]    dv_en_i,
    input  logic [CW-1:0]    ratio_i,
    input  logic [CW-1:0]    phase_i,
    input  logic             sync_i,
    input  logic [CH-1:0]    adc_dv_i,
    input  logic [CH*DW-1:0] adc_dat_i,
    output logic [CH-1:0]    adc_dv_o,
    output logic [CH*DW-1:0] adc_dat_o,
    output logic [CW-1:0]    ratio_o
`ifdef RP_DV_DECIM_STAT_EN
    ,
    output logic [CH*32-1:0] drop_cnt_o
`endif
);

    logic [CW-1:0] ratio_act_reg;
    logic [CW-1:0] ratio_new;
    logic [CW-1:0] phase_new;
    logic [CW-1:0] sync_inc;

    // The active phase only matters on the sync cycle itself, so it is consumed
    // directly from the clamped request rather than stored.
    always_comb begin
        ratio_new = (ratio_i < CW'(2)) ? CW'(1) : ratio_i;
        phase_new = (phase_i >= ratio_new) ? '0 : phase_i;
        sync_inc  = phase_new + CW'(1);
    end

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            ratio_act_reg <= CW'(2);
        end else if (sync_i) begin
            ratio_act_reg <= ratio_new;
        end
    end

    assign ratio_o = ratio_act_reg;

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_next;
            logic [CW-1:0] cnt_inc;
            logic          dv_reg;
            logic          dv_next;
            logic [DW-1:0] dat_reg;

            always_comb begin
                cnt_inc  = cnt_reg + CW'(1);
                cnt_next = cnt_reg;
                dv_next  = 1'b0;
                if (sync_i) begin
                    if (adc_dv_i[gi] && dv_en_i[gi]) begin
                        dv_next  = (phase_new == '0);
                        cnt_next = (sync_inc == ratio_new) ? '0 : sync_inc;
                    end else begin
                        // A disabled channel still passes its valid straight through.
                        dv_next  = adc_dv_i[gi] & ~dv_en_i[gi];
                        cnt_next = phase_new;
                    end
                end else if (!dv_en_i[gi]) begin
                    dv_next = adc_dv_i[gi];
                end else if (adc_dv_i[gi]) begin
                    dv_next  = (cnt_reg == '0);
                    cnt_next = (cnt_inc == ratio_act_reg) ? '0 : cnt_inc;
                end
            end

            always_ff @(posedge adc_clk_i) begin
                if (adc_rst_i) begin
                    cnt_reg <= '0;
                    dv_reg  <= 1'b0;
                    dat_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                    dv_reg  <= dv_next;
                    if (dv_next) begin
                        dat_reg <= adc_dat_i[gi*DW +: DW];
                    end
                end
            end

            assign adc_dv_o[gi]            = dv_reg;
            assign adc_dat_o[gi*DW +: DW]  = dat_reg;

`ifdef RP_DV_DECIM_STAT_EN
            logic [31:0] drop_cnt_reg;
            logic        drop;

            assign drop = !sync_i && dv_en_i[gi] && adc_dv_i[gi] && (cnt_reg != '0);

            always_ff @(posedge adc_clk_i) begin
                if (adc_rst_i || sync_i) begin
                    drop_cnt_reg <= '0;
                end else if (drop && (drop_cnt_reg != '1)) begin
                    drop_cnt_reg <= drop_cnt_reg + 32'd1;
                end
            end

            assign drop_cnt_o[gi*32 +: 32] = drop_cnt_reg;
`endif
        end
    endgenerate

endmodule
